// File: rtl/mm_access_ctrl.sv
// mm_access_ctrl: memory-stage access controller. Turns EX/MM load/store
// requests into a valid/ready data-memory handshake, waits for the read
// response with a bounded timeout, and produces a one-cycle writeback or
// fault pulse. ALU-only results pass straight through to writeback.
module mm_access_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic                  reg_write_in,
  input  logic [DATA_WIDTH-1:0] alu_result_in,
  input  logic [DATA_WIDTH-1:0] write_data_in,
  input  logic [4:0]            rd_in,
  output logic                  dmem_req_valid,
  input  logic                  dmem_req_ready,
  output logic                  dmem_req_we,
  output logic [DATA_WIDTH-1:0] dmem_req_addr,
  output logic [DATA_WIDTH-1:0] dmem_req_wdata,
  input  logic                  dmem_resp_valid,
  input  logic [DATA_WIDTH-1:0] dmem_resp_rdata,
  output logic                  stall,
  output logic                  wb_valid,
  output logic [4:0]            wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  mem_err
);

  // Counter wide enough to hold TIMEOUT-1.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [4:0]            rd_q, rd_d;
  logic                  we_q, we_d;
  logic                  wb_valid_q, wb_valid_d;
  logic [4:0]            wb_rd_q, wb_rd_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic                  mem_err_q, mem_err_d;

  logic mem_op_s;
  logic dual_s;
  logic misalign_s;

  // Request decode: exactly one of read/write is a legal memory operation.
  assign mem_op_s   = mem_read_in ^ mem_write_in;
  assign dual_s     = mem_read_in & mem_write_in;
  assign misalign_s = (alu_result_in[1:0] != 2'b00);

  // Next-state and next-output logic; event pulses default low every cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    we_d       = we_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    mem_err_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dual_s || (mem_op_s && misalign_s)) begin
          // Illegal access: flag it, never touch memory.
          mem_err_d = 1'b1;
        end else if (mem_op_s) begin
          addr_d  = alu_result_in;
          wdata_d = write_data_in;
          rd_d    = rd_in;
          we_d    = mem_write_in;
          state_d = S_REQ;
        end else if (reg_write_in) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_in;
          wb_data_d  = alu_result_in;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (dmem_req_ready) begin
          if (we_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT;
            cnt_d   = {CW{1'b0}};
          end
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        // A response on the final timeout cycle still wins over the abort.
        if (dmem_resp_valid) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = dmem_resp_rdata;
          cnt_d      = {CW{1'b0}};
          state_d    = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          mem_err_d = 1'b1;
          cnt_d     = {CW{1'b0}};
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= {CW{1'b0}};
      addr_q     <= {DATA_WIDTH{1'b0}};
      wdata_q    <= {DATA_WIDTH{1'b0}};
      rd_q       <= 5'd0;
      we_q       <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= {DATA_WIDTH{1'b0}};
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      we_q       <= we_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      mem_err_q  <= mem_err_d;
    end
  end

  // Request channel is a pure decode of the REQ state plus latched fields.
  assign dmem_req_valid = (state_q == S_REQ);
  assign dmem_req_we    = we_q;
  assign dmem_req_addr  = addr_q;
  assign dmem_req_wdata = wdata_q;

  // Stall freezes upstream while busy or while any memory request is presented.
  assign stall = ~rst & ((state_q != S_IDLE) | mem_read_in | mem_write_in);

  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
  assign mem_err  = mem_err_q;

endmodule

// File: tb/tb_mm_access_ctrl.sv
// Directed self-checking bench for mm_access_ctrl (DATA_WIDTH=32, TIMEOUT=16).
module tb_mm_access_ctrl;

  logic        clk;
  logic        rst;
  logic        mem_read_in;
  logic        mem_write_in;
  logic        reg_write_in;
  logic [31:0] alu_result_in;
  logic [31:0] write_data_in;
  logic [4:0]  rd_in;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_req_we;
  logic [31:0] dmem_req_addr;
  logic [31:0] dmem_req_wdata;
  logic        dmem_resp_valid;
  logic [31:0] dmem_resp_rdata;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mem_err;

  int errors = 0;
  int checks = 0;
  int n_wait;

  mm_access_ctrl #(.DATA_WIDTH(32), .TIMEOUT(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_read_in    (mem_read_in),
    .mem_write_in   (mem_write_in),
    .reg_write_in   (reg_write_in),
    .alu_result_in  (alu_result_in),
    .write_data_in  (write_data_in),
    .rd_in          (rd_in),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_req_we    (dmem_req_we),
    .dmem_req_addr  (dmem_req_addr),
    .dmem_req_wdata (dmem_req_wdata),
    .dmem_resp_valid(dmem_resp_valid),
    .dmem_resp_rdata(dmem_resp_rdata),
    .stall          (stall),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .mem_err        (mem_err)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle away from the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    mem_read_in     = 1'b0;
    mem_write_in    = 1'b0;
    reg_write_in    = 1'b0;
    alu_result_in   = 32'h0;
    write_data_in   = 32'h0;
    rd_in           = 5'd0;
    dmem_req_ready  = 1'b0;
    dmem_resp_valid = 1'b0;
    dmem_resp_rdata = 32'h0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;

    // ---- reset state; stall forced low while in reset ----
    step();
    step();
    mem_read_in = 1'b1;
    #1;
    chk1("rst_stall", stall, 1'b0);
    mem_read_in = 1'b0;
    chk1("rst_wb_valid", wb_valid, 1'b0);
    chk1("rst_mem_err", mem_err, 1'b0);
    chk1("rst_req_valid", dmem_req_valid, 1'b0);
    chk32("rst_wb_data", wb_data, 32'h0);
    chk32("rst_addr", dmem_req_addr, 32'h0);
    rst = 1'b0;
    step();

    // ---- ALU pass-through: rd=7, 0x55 ----
    reg_write_in  = 1'b1;
    rd_in         = 5'd7;
    alu_result_in = 32'h55;
    #1;
    chk1("alu_stall_pre", stall, 1'b0);
    step();
    clear_inputs();
    #1;
    chk1("alu_wb_valid", wb_valid, 1'b1);
    chk32("alu_wb_rd", {27'd0, wb_rd}, 32'd7);
    chk32("alu_wb_data", wb_data, 32'h55);
    chk1("alu_stall_post", stall, 1'b0);
    step();
    chk1("alu_wb_pulse_end", wb_valid, 1'b0);

    // ---- load, ready=1, response 2 cycles into WAIT ----
    mem_read_in   = 1'b1;
    alu_result_in = 32'h40;
    rd_in         = 5'd5;
    #1;
    chk1("ld_stall_idle", stall, 1'b1);
    chk1("ld_req_idle", dmem_req_valid, 1'b0);
    step();
    clear_inputs();
    dmem_req_ready = 1'b1;
    #1;
    chk1("ld_req_valid", dmem_req_valid, 1'b1);
    chk32("ld_req_addr", dmem_req_addr, 32'h40);
    chk1("ld_req_we", dmem_req_we, 1'b0);
    chk1("ld_stall_req", stall, 1'b1);
    step();
    dmem_req_ready = 1'b0;
    #1;
    chk1("ld_w0_req_valid", dmem_req_valid, 1'b0);
    chk1("ld_w0_stall", stall, 1'b1);
    step();
    chk1("ld_w1_stall", stall, 1'b1);
    chk1("ld_w1_wb", wb_valid, 1'b0);
    step();
    dmem_resp_valid = 1'b1;
    dmem_resp_rdata = 32'hDEADBEEF;
    #1;
    chk1("ld_w2_stall", stall, 1'b1);
    step();
    dmem_resp_valid = 1'b0;
    dmem_resp_rdata = 32'h0;
    #1;
    chk1("ld_wb_valid", wb_valid, 1'b1);
    chk32("ld_wb_rd", {27'd0, wb_rd}, 32'd5);
    chk32("ld_wb_data", wb_data, 32'hDEADBEEF);
    chk1("ld_wb_mem_err", mem_err, 1'b0);
    chk1("ld_wb_stall", stall, 1'b0);
    step();
    chk1("ld_wb_pulse_end", wb_valid, 1'b0);

    // ---- store 0x1234 @0x100, ready low 3 cycles ----
    mem_write_in  = 1'b1;
    alu_result_in = 32'h100;
    write_data_in = 32'h1234;
    step();
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      dmem_req_ready = (i == 3) ? 1'b1 : 1'b0;
      #1;
      chk1("st_req_valid", dmem_req_valid, 1'b1);
      chk32("st_req_addr", dmem_req_addr, 32'h100);
      chk32("st_req_wdata", dmem_req_wdata, 32'h1234);
      chk1("st_req_we", dmem_req_we, 1'b1);
      step();
    end
    dmem_req_ready = 1'b0;
    #1;
    chk1("st_done_req_valid", dmem_req_valid, 1'b0);
    chk1("st_done_wb", wb_valid, 1'b0);
    chk1("st_done_stall", stall, 1'b0);
    step();
    chk1("st_after_wb", wb_valid, 1'b0);
    chk1("st_after_req_valid", dmem_req_valid, 1'b0);

    // ---- load timeout: 16 WAIT cycles then mem_err ----
    mem_read_in   = 1'b1;
    alu_result_in = 32'h200;
    rd_in         = 5'd3;
    step();
    clear_inputs();
    dmem_req_ready = 1'b1;
    step();
    dmem_req_ready = 1'b0;
    n_wait = 0;
    #1;
    while (stall === 1'b1 && n_wait < 40) begin
      chk1("to_wait_wb", wb_valid, 1'b0);
      chk1("to_wait_req_valid", dmem_req_valid, 1'b0);
      n_wait++;
      step();
    end
    chk32("to_wait_cycles", 32'(n_wait), 32'd16);
    chk1("to_mem_err", mem_err, 1'b1);
    chk1("to_wb_valid", wb_valid, 1'b0);
    step();
    chk1("to_mem_err_end", mem_err, 1'b0);

    // ---- response on the final timeout cycle wins ----
    mem_read_in   = 1'b1;
    alu_result_in = 32'h204;
    rd_in         = 5'd12;
    step();
    clear_inputs();
    dmem_req_ready = 1'b1;
    step();
    dmem_req_ready = 1'b0;
    for (int i = 0; i < 15; i++) step();
    dmem_resp_valid = 1'b1;
    dmem_resp_rdata = 32'hA5A50F0F;
    #1;
    chk1("edge_stall", stall, 1'b1);
    step();
    dmem_resp_valid = 1'b0;
    #1;
    chk1("edge_wb_valid", wb_valid, 1'b1);
    chk1("edge_mem_err", mem_err, 1'b0);
    chk32("edge_wb_data", wb_data, 32'hA5A50F0F);
    chk32("edge_wb_rd", {27'd0, wb_rd}, 32'd12);
    step();

    // ---- misaligned load 0x102 ----
    mem_read_in   = 1'b1;
    alu_result_in = 32'h102;
    rd_in         = 5'd4;
    #1;
    chk1("mis_stall", stall, 1'b1);
    step();
    clear_inputs();
    #1;
    chk1("mis_mem_err", mem_err, 1'b1);
    chk1("mis_wb", wb_valid, 1'b0);
    chk1("mis_req_valid", dmem_req_valid, 1'b0);
    chk1("mis_stall_after", stall, 1'b0);
    step();
    chk1("mis_mem_err_end", mem_err, 1'b0);
    chk1("mis_req_valid2", dmem_req_valid, 1'b0);

    // ---- read and write both asserted ----
    mem_read_in   = 1'b1;
    mem_write_in  = 1'b1;
    alu_result_in = 32'h100;
    step();
    clear_inputs();
    #1;
    chk1("dual_mem_err", mem_err, 1'b1);
    chk1("dual_wb", wb_valid, 1'b0);
    chk1("dual_req_valid", dmem_req_valid, 1'b0);
    step();
    chk1("dual_mem_err_end", mem_err, 1'b0);
    chk1("dual_req_valid2", dmem_req_valid, 1'b0);

    // ---- stray response in IDLE is ignored ----
    dmem_resp_valid = 1'b1;
    dmem_resp_rdata = 32'h77;
    step();
    clear_inputs();
    #1;
    chk1("stray_wb", wb_valid, 1'b0);
    chk1("stray_mem_err", mem_err, 1'b0);

    // ---- reset during WAIT, then a late response ----
    mem_read_in   = 1'b1;
    alu_result_in = 32'h300;
    write_data_in = 32'h99;
    rd_in         = 5'd9;
    step();
    clear_inputs();
    dmem_req_ready = 1'b1;
    step();
    dmem_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk1("rw_stall_in_rst", stall, 1'b0);
    step();
    rst = 1'b0;
    dmem_resp_valid = 1'b1;
    dmem_resp_rdata = 32'hCAFE;
    #1;
    chk1("rw_req_valid", dmem_req_valid, 1'b0);
    chk1("rw_wb", wb_valid, 1'b0);
    chk1("rw_mem_err", mem_err, 1'b0);
    chk32("rw_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk32("rw_wb_data", wb_data, 32'h0);
    chk32("rw_addr", dmem_req_addr, 32'h0);
    chk32("rw_wdata", dmem_req_wdata, 32'h0);
    chk1("rw_we", dmem_req_we, 1'b0);
    chk1("rw_stall", stall, 1'b0);
    step();
    clear_inputs();
    #1;
    chk1("rw_late_wb", wb_valid, 1'b0);
    chk1("rw_late_mem_err", mem_err, 1'b0);
    chk1("rw_late_req_valid", dmem_req_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mm_access_ctrl.md
MM_ACCESS_CTRL -- requirements
Module: mm_access_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the address and data width.
REQ-002 Parameter TIMEOUT, default 16, SHALL set the maximum number of WAIT cycles before an abort.
REQ-003 Ports SHALL be:
- clk  in  1  clock; one clock domain only.
- rst  in  1  synchronous, active-high reset.
- mem_read_in  in  1  EX/MM load request.
- mem_write_in  in  1  EX/MM store request.
- reg_write_in  in  1  EX/MM register-write enable.
- alu_result_in  in  DATA_WIDTH  effective address, or ALU result for non-memory operations.
- write_data_in  in  DATA_WIDTH  store data.
- rd_in  in  5  destination register.
- dmem_req_valid  out  1  memory request valid.
- dmem_req_ready  in  1  memory accepts the request.
- dmem_req_we  out  1  1 = write.
- dmem_req_addr  out  DATA_WIDTH  request address.
- dmem_req_wdata  out  DATA_WIDTH  request write data.
- dmem_resp_valid  in  1  read data valid.
- dmem_resp_rdata  in  DATA_WIDTH  read data.
- stall  out  1  freeze the EX/MM register and all upstream stages.
- wb_valid  out  1  writeback pulse.
- wb_rd  out  5  writeback register.
- wb_data  out  DATA_WIDTH  writeback data.
- mem_err  out  1  one-cycle fault pulse.

Function
REQ-004 FSM states SHALL be IDLE, REQ and WAIT; the reset state SHALL be IDLE.
REQ-005 In IDLE, a memory operation SHALL be present when mem_read_in XOR mem_write_in is 1.
REQ-006 On a memory operation in IDLE with alu_result_in[1:0]==0, the block SHALL latch addr, wdata, rd and the write flag, then go to REQ.
REQ-007 In IDLE with mem_read_in and mem_write_in both 1, or with a misaligned address (alu_result_in[1:0]!=0) on a memory operation:
- next cycle mem_err=1 for one cycle;
- no request issued; wb_valid=0; stay in IDLE.
REQ-008 In IDLE with no memory operation and reg_write_in=1, the next cycle SHALL give wb_valid=1, wb_rd=rd_in, wb_data=alu_result_in (latency 1).
REQ-009 stall SHALL be combinational: 1 when state!=IDLE, or when in IDLE with any memory-operation request (valid, dual or misaligned); 0 otherwise.
REQ-010 In REQ:
- dmem_req_valid=1;
- addr, wdata and we driven from the latched values, held stable until dmem_req_ready=1.
REQ-011 In REQ when dmem_req_ready=1:
- write: go to IDLE; wb_valid stays 0;
- read: go to WAIT with the timeout counter cleared.
REQ-012 In WAIT, dmem_resp_valid=1 SHALL capture dmem_resp_rdata; the next cycle gives wb_valid=1, wb_rd=latched rd, wb_data=rdata, and state is IDLE.
REQ-013 In WAIT without a response, the counter SHALL increment each cycle.
REQ-014 When the counter equals TIMEOUT-1 with no response, the block SHALL go to IDLE, pulse mem_err for one cycle and suppress wb_valid.
REQ-015 A response arriving in the same cycle the counter reaches TIMEOUT-1 SHALL win: normal writeback, no mem_err.
REQ-016 dmem_resp_valid outside WAIT SHALL be ignored.
REQ-017 dmem_req_valid SHALL be 0 in IDLE and WAIT.
REQ-018 wb_valid and mem_err SHALL never be 1 in the same cycle, and each SHALL be high for exactly one cycle per event.
REQ-019 Minimum latency from memory operation to writeback:
- load with ready and response both immediate: IDLE->REQ->WAIT->wb, i.e. wb_valid 3 cycles after the operation is presented;
- store: back in IDLE 2 cycles after.

Reset
REQ-020 rst=1 at a clock edge SHALL force state=IDLE and counter=0.
REQ-021 rst SHALL force all registered outputs to 0: wb_valid, wb_rd, wb_data, mem_err, and the latched addr, wdata and we.
REQ-022 Reset mid-operation (REQ or WAIT) SHALL abandon the access: dmem_req_valid=0 from the cycle after reset, with no wb_valid and no mem_err.
REQ-023 While rst=1, stall SHALL be driven 0.

Verification
REQ-024 Load, ready=1, response 2 cycles after entering WAIT, rdata=0xDEADBEEF, rd=5 -> one wb_valid pulse with wb_rd=5, wb_data=0xDEADBEEF; stall high from presentation until the wb cycle.
REQ-025 Store addr=0x100, wdata=0x1234, ready held low 3 cycles -> addr, wdata and we=1 stable for 4 request cycles, one acceptance, no wb_valid, back in IDLE.
REQ-026 Load with no response, TIMEOUT=16 -> exactly 16 WAIT cycles, one mem_err pulse, no wb_valid, back in IDLE.
REQ-027 Misaligned load addr=0x102, then a separate test with read=write=1 -> mem_err pulse, dmem_req_valid never asserted.
REQ-028 ALU op reg_write_in=1, rd=7, alu_result_in=0x55 -> wb_valid next cycle, wb_data=0x55, stall=0 throughout.
REQ-029 rst asserted during WAIT, then a late dmem_resp_valid -> IDLE, no wb_valid, no mem_err, all outputs 0.
